// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the N-master QoS write-address arbiter.
package axi_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam int unsigned QOS_W_DEFAULT = 4;

  // LSB of master idx's field inside the packed AxQOS bus.
  function automatic int unsigned qos_lsb(input int unsigned idx, input int unsigned qos_w);
    return idx * qos_w;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Round-robin picker: first set bit of mask at or after start, wrapping modulo N.
// Returns 0 when the mask is empty; callers only use the result when a request exists.
module arb_rr_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = $clog2(N)
) (
  input  logic [N-1:0]    mask,
  input  logic [ID_W-1:0] start,
  output logic [ID_W-1:0] pick
);

  logic found;

  // Scan N positions starting at the pointer; the first hit wins.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && mask[(32'(start) + k) % N]) begin
        pick  = ID_W'((32'(start) + k) % N);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_qos_arbiter_n.sv
// N-master QoS write-address arbiter: max-qos selection with round-robin tie-break,
// grant held until the address handshake completes.
// Optional starvation aging is built when AXI_QOS_AGING_EN is defined.
module axi_qos_arbiter_n
  import axi_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned QOS_W       = QOS_W_DEFAULT,
  parameter int unsigned ID_W        = $clog2(NUM_MASTERS),
  parameter int unsigned AGE_W       = 4,
  parameter int unsigned AGE_LIMIT   = 8
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  input  logic [NUM_MASTERS-1:0]       M_valid,
  input  logic [NUM_MASTERS*QOS_W-1:0] M_qos,
  input  logic                         Channel_Granted,
  input  logic                         Token,
  input  logic                         Txn_Done,
  output logic                         Channel_Request,
  output logic [ID_W-1:0]              Selected_Master,
  output logic                         Grant_Valid
);

  arb_state_e             state_q;
  logic [ID_W-1:0]        last_winner_q;
  logic [ID_W-1:0]        rr_start;
  logic [ID_W-1:0]        winner;
  logic [QOS_W-1:0]       max_qos;
  logic [NUM_MASTERS-1:0] max_mask;
  logic [NUM_MASTERS-1:0] urgent_mask;
  logic [NUM_MASTERS-1:0] cand_mask;
  logic                   arb_event;

  assign arb_event       = (state_q == ARB_IDLE) & Channel_Granted & ~Token & (|M_valid);
  assign Channel_Request = arb_event;

  // Highest qos among the valid masters.
  always_comb begin
    max_qos = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (M_valid[i] && (M_qos[qos_lsb(i, QOS_W) +: QOS_W] > max_qos)) begin
        max_qos = M_qos[qos_lsb(i, QOS_W) +: QOS_W];
      end
    end
  end

  // Valid masters tied at the maximum qos.
  always_comb begin
    max_mask = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      max_mask[i] = M_valid[i] && (M_qos[qos_lsb(i, QOS_W) +: QOS_W] == max_qos);
    end
  end

`ifdef AXI_QOS_AGING_EN
  logic [AGE_W-1:0] age_q [NUM_MASTERS];

  // Valid masters that have waited long enough to pre-empt qos ordering.
  always_comb begin
    urgent_mask = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      urgent_mask[i] = M_valid[i] && (age_q[i] >= AGE_W'(AGE_LIMIT));
    end
  end

  // Ages move only on arbitration events: winner clears, losers saturate upward.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int unsigned i = 0; i < NUM_MASTERS; i++) age_q[i] <= '0;
    end else if (arb_event) begin
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        if (ID_W'(i) == winner) begin
          age_q[i] <= '0;
        end else if (M_valid[i]) begin
          if (age_q[i] < AGE_W'(AGE_LIMIT)) age_q[i] <= age_q[i] + 1'b1;
        end else begin
          age_q[i] <= '0;
        end
      end
    end
  end
`else
  assign urgent_mask = '0;
`endif

  assign cand_mask = (|urgent_mask) ? urgent_mask : max_mask;
  assign rr_start  = (last_winner_q == ID_W'(NUM_MASTERS - 1)) ? '0 : last_winner_q + 1'b1;

  arb_rr_pick #(
    .N    (NUM_MASTERS),
    .ID_W (ID_W)
  ) u_rr_pick (
    .mask  (cand_mask),
    .start (rr_start),
    .pick  (winner)
  );

  // Grant FSM: latch winner on an event, hold it until the handshake completes.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q         <= ARB_IDLE;
      Selected_Master <= '0;
      Grant_Valid     <= 1'b0;
      last_winner_q   <= ID_W'(NUM_MASTERS - 1);
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (arb_event) begin
            Selected_Master <= winner;
            Grant_Valid     <= 1'b1;
            last_winner_q   <= winner;
            state_q         <= ARB_LOCKED;
          end
        end
        ARB_LOCKED: begin
          if (Txn_Done) begin
            Grant_Valid <= 1'b0;
            state_q     <= ARB_IDLE;
          end
        end
      endcase
    end
  end

endmodule
